pc_branch_unit: RTL and testbench

Parametrised program-counter and branch-resolution unit; successor to the single-width RV32I PC. Holds the fetch address, resolves conditional branches from the ALU compare flags, and handles JAL/JALR jumps and misaligned-target traps. Handshakes each fetch with the instruction memory and inserts a configurable flush bubble after every redirect. Sits between the decode/ALU stage and instruction memory.

---
 rtl/pc_branch_unit.sv | 192 +++++++++++++++++++
 tb/tb_pc_branch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Program counter with branch/jump resolution, misaligned-target traps,
// fetch handshake and a configurable flush bubble after every redirect.
module pc_branch_unit #(
  parameter int                 dataW        = 32,
  parameter logic [dataW-1:0]   RESET_VECTOR = {dataW{1'b0}},
  parameter logic [dataW-1:0]   TRAP_VECTOR  = dataW'(32'h0000_0100),
  parameter int                 IALIGN       = 32,
  parameter int                 FLUSH        = 1,
  parameter int                 CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EQ,
  input  logic             NE,
  input  logic             LT,
  input  logic             LTU,
  input  logic             GE,
  input  logic             GEU,
  input  logic             BranchControl,
  input  logic [2:0]       PCBranchType,
  input  logic [1:0]       JumpType,
  input  logic [dataW-1:0] BranchOffset,
  input  logic [dataW-1:0] JumpBase,
  input  logic             Stall,
  input  logic             FetchReady,
  output logic [dataW-1:0] ProgAddr,
  output logic             FetchValid,
  output logic [dataW-1:0] LinkAddr,
  output logic             Trap,
  output logic [dataW-1:0] TrapValue,
  output logic [CNT_W-1:0] InstRet
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [dataW-1:0] ADDR_STEP  = dataW'(32'd4);
  localparam logic             FLUSH_EN   = (FLUSH > 0) ? 1'b1 : 1'b0;
  // Counter holds remaining bubbles minus one, so a load of FLUSH-1 yields FLUSH low cycles.
  localparam logic [1:0]       FLUSH_LOAD = (FLUSH > 0) ? 2'(FLUSH - 1) : 2'd0;

  function automatic logic misaligned_f(input logic [dataW-1:0] addr);
    logic bad;
    if (IALIGN == 16) begin
      bad = addr[0];
    end else begin
      bad = addr[1] | addr[0];
    end
    return bad;
  endfunction

  function automatic logic branch_cond_f(input logic [2:0] f3, input logic eq, input logic ne,
                                         input logic lt, input logic ge, input logic ltu,
                                         input logic geu);
    logic taken;
    case (f3)
      3'b000:  taken = eq;
      3'b001:  taken = ne;
      3'b100:  taken = lt;
      3'b101:  taken = ge;
      3'b110:  taken = ltu;
      3'b111:  taken = geu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [1:0]         flush_cnt_r;
  logic [1:0]         flush_cnt_next_s;
  logic [dataW-1:0]   prog_addr_r;
  logic [dataW-1:0]   prog_addr_next_s;
  logic               fetch_valid_r;
  logic               trap_r;
  logic [dataW-1:0]   trap_value_r;
  logic [CNT_W-1:0]   inst_ret_r;

  logic               advance_s;
  logic               is_jal_s;
  logic               is_jalr_s;
  logic               taken_s;
  logic               redirect_s;
  logic               trap_s;
  logic [dataW-1:0]   pc_plus4_s;
  logic [dataW-1:0]   pc_rel_s;
  logic [dataW-1:0]   jalr_sum_s;
  logic [dataW-1:0]   target_s;

  // Target resolution and next fetch address.
  always_comb begin
    advance_s  = (state_r == S_RUN) & fetch_valid_r & FetchReady & ~Stall;
    is_jal_s   = (JumpType == 2'b01);
    is_jalr_s  = (JumpType == 2'b10);
    taken_s    = BranchControl & ~is_jal_s & ~is_jalr_s &
                 branch_cond_f(PCBranchType, EQ, NE, LT, GE, LTU, GEU);
    redirect_s = is_jal_s | is_jalr_s | taken_s;
    pc_plus4_s = prog_addr_r + ADDR_STEP;
    pc_rel_s   = prog_addr_r + BranchOffset;
    jalr_sum_s = JumpBase + BranchOffset;
    if (is_jalr_s) begin
      target_s = {jalr_sum_s[dataW-1:1], 1'b0};
    end else begin
      target_s = pc_rel_s;
    end
    trap_s = redirect_s & misaligned_f(target_s);

    prog_addr_next_s = prog_addr_r;
    if (!advance_s) begin
      prog_addr_next_s = prog_addr_r;
    end else if (trap_s) begin
      prog_addr_next_s = TRAP_VECTOR;
    end else if (redirect_s) begin
      prog_addr_next_s = target_s;
    end else begin
      prog_addr_next_s = pc_plus4_s;
    end
  end

  // Sequencer next state: BOOT -> RUN, RUN -> FLUSH on redirect, FLUSH counts down.
  always_comb begin
    state_next_s     = state_r;
    flush_cnt_next_s = flush_cnt_r;
    case (state_r)
      S_BOOT: begin
        state_next_s = S_RUN;
      end
      S_RUN: begin
        if (advance_s && redirect_s && FLUSH_EN) begin
          state_next_s     = S_FLUSH;
          flush_cnt_next_s = FLUSH_LOAD;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_r == 2'd0) begin
          state_next_s = S_RUN;
        end else begin
          flush_cnt_next_s = flush_cnt_r - 2'd1;
        end
      end
      default: begin
        state_next_s     = S_BOOT;
        flush_cnt_next_s = 2'd0;
      end
    endcase
  end

  // State, flush counter and fetch-valid registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= S_BOOT;
      flush_cnt_r   <= 2'd0;
      fetch_valid_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      flush_cnt_r   <= flush_cnt_next_s;
      fetch_valid_r <= (state_next_s == S_RUN);
    end
  end

  // Fetch address, trap reporting and retired-fetch counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prog_addr_r  <= RESET_VECTOR;
      trap_r       <= 1'b0;
      trap_value_r <= {dataW{1'b0}};
      inst_ret_r   <= {CNT_W{1'b0}};
    end else begin
      prog_addr_r <= prog_addr_next_s;
      trap_r      <= advance_s & trap_s;
      if (advance_s && trap_s) begin
        trap_value_r <= target_s;
      end
      if (advance_s) begin
        inst_ret_r <= inst_ret_r + CNT_W'(1'b1);
      end
    end
  end

  assign ProgAddr   = prog_addr_r;
  assign FetchValid = fetch_valid_r;
  assign LinkAddr   = pc_plus4_s;
  assign Trap       = trap_r;
  assign TrapValue  = trap_value_r;
  assign InstRet    = inst_ret_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit with default parameters.
module tb_pc_branch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        EQ, NE, LT, LTU, GE, GEU;
  logic        BranchControl;
  logic [2:0]  PCBranchType;
  logic [1:0]  JumpType;
  logic [31:0] BranchOffset;
  logic [31:0] JumpBase;
  logic        Stall;
  logic        FetchReady;
  logic [31:0] ProgAddr;
  logic        FetchValid;
  logic [31:0] LinkAddr;
  logic        Trap;
  logic [31:0] TrapValue;
  logic [31:0] InstRet;

  int n_cmp = 0;
  int n_err = 0;

  pc_branch_unit #(
    .dataW(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h0000_0100),
    .IALIGN(32), .FLUSH(1), .CNT_W(32)
  ) dut (
    .clock(clock), .reset(reset),
    .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
    .BranchControl(BranchControl), .PCBranchType(PCBranchType), .JumpType(JumpType),
    .BranchOffset(BranchOffset), .JumpBase(JumpBase),
    .Stall(Stall), .FetchReady(FetchReady),
    .ProgAddr(ProgAddr), .FetchValid(FetchValid), .LinkAddr(LinkAddr),
    .Trap(Trap), .TrapValue(TrapValue), .InstRet(InstRet)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    {EQ, NE, LT, LTU, GE, GEU} = 6'b000000;
    BranchControl = 1'b0;
    PCBranchType  = 3'b000;
    JumpType      = 2'b00;
    BranchOffset  = 32'h0;
    JumpBase      = 32'h0;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pa, input logic fv,
                        input logic [31:0] ir);
    check_eq({tag, ".pc"}, 64'(ProgAddr), 64'(pa));
    check_eq({tag, ".fv"}, 64'(FetchValid), 64'(fv));
    check_eq({tag, ".ir"}, 64'(InstRet), 64'(ir));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    Stall = 1'b0;
    FetchReady = 1'b1;
    clr_in();
    #3;
    chk_pc("rst", 32'h0, 1'b0, 32'd0);
    check_eq("rst.trap", 64'(Trap), 64'd0);
    check_eq("rst.tval", 64'(TrapValue), 64'd0);

    // Boot and sequential fetch
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_pc("boot", 32'h0, 1'b0, 32'd0);
    tick(); chk_pc("run0", 32'd0, 1'b1, 32'd0);
    tick(); chk_pc("run4", 32'd4, 1'b1, 32'd1);
    tick(); chk_pc("run8", 32'd8, 1'b1, 32'd2);

    // BEQ not taken: no bubble
    BranchControl = 1'b1; PCBranchType = 3'b000; BranchOffset = 32'd40; EQ = 1'b0; NE = 1'b1;
    tick(); chk_pc("beq_nt", 32'd12, 1'b1, 32'd3);
    clr_in();
    tick(); chk_pc("seq16", 32'd16, 1'b1, 32'd4);

    // BGE taken backwards
    BranchControl = 1'b1; PCBranchType = 3'b101; GE = 1'b1; BranchOffset = 32'hFFFF_FFF8;
    tick(); chk_pc("bge", 32'd8, 1'b0, 32'd5);
    clr_in();
    tick(); chk_pc("bge_fl", 32'd8, 1'b1, 32'd5);

    // BEQ taken with one bubble
    BranchControl = 1'b1; PCBranchType = 3'b000; EQ = 1'b1; BranchOffset = 32'd40;
    tick(); chk_pc("beq_t", 32'd48, 1'b0, 32'd6);
    clr_in();
    tick(); chk_pc("beq_fl", 32'd48, 1'b1, 32'd6);
    tick(); chk_pc("seq52", 32'd52, 1'b1, 32'd7);

    // BLTU with LTU=0, other flags set
    BranchControl = 1'b1; PCBranchType = 3'b110; BranchOffset = 32'd100;
    {EQ, NE, LT, LTU, GE, GEU} = 6'b111011;
    tick(); chk_pc("bltu_nt", 32'd56, 1'b1, 32'd8);

    // Reserved funct3 never taken
    PCBranchType = 3'b010; {EQ, NE, LT, LTU, GE, GEU} = 6'b111111;
    tick(); chk_pc("f3_010", 32'd60, 1'b1, 32'd9);

    // JALR to misaligned target traps
    clr_in();
    JumpType = 2'b10; JumpBase = 32'h203; BranchOffset = 32'h0;
    check_eq("link60", 64'(LinkAddr), 64'd64);
    tick(); chk_pc("jalr_trap", 32'h100, 1'b0, 32'd10);
    check_eq("trap.hi", 64'(Trap), 64'd1);
    check_eq("trap.val", 64'(TrapValue), 64'h202);
    clr_in();
    tick(); chk_pc("trap_fl", 32'h100, 1'b1, 32'd10);
    check_eq("trap.lo", 64'(Trap), 64'd0);
    check_eq("trap.hold", 64'(TrapValue), 64'h202);

    // JALR clears bit 0: no trap
    JumpType = 2'b10; JumpBase = 32'h205; BranchOffset = 32'hFFFF_FFFF;
    tick(); chk_pc("jalr_ok", 32'h204, 1'b0, 32'd11);
    check_eq("jalr_ok.trap", 64'(Trap), 64'd0);
    clr_in();
    tick();

    // Jump overrides a taken branch
    JumpType = 2'b10; JumpBase = 32'h1000; BranchOffset = 32'd8;
    BranchControl = 1'b1; PCBranchType = 3'b000; EQ = 1'b1;
    tick(); chk_pc("jmp_ovr", 32'h1008, 1'b0, 32'd12);
    clr_in();
    tick();

    // JAL to misaligned target
    JumpType = 2'b01; BranchOffset = 32'd6;
    tick(); chk_pc("jal_trap", 32'h100, 1'b0, 32'd13);
    check_eq("jal_trap.hi", 64'(Trap), 64'd1);
    check_eq("jal_trap.val", 64'(TrapValue), 64'h100E);
    clr_in();
    tick(); chk_pc("jal_fl", 32'h100, 1'b1, 32'd13);

    // Stall and FetchReady=0 hold everything
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      JumpType = 2'(i); BranchControl = 1'b1; EQ = 1'b1; BranchOffset = 32'h40;
      tick(); chk_pc("stall", 32'h100, 1'b1, 32'd13);
    end
    Stall = 1'b0; FetchReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      JumpType = 2'b01; BranchOffset = 32'(i * 16);
      tick(); chk_pc("nrdy", 32'h100, 1'b1, 32'd13);
    end
    FetchReady = 1'b1;
    clr_in();
    tick(); chk_pc("resume", 32'h104, 1'b1, 32'd14);

    // Address wrap
    JumpType = 2'b10; JumpBase = 32'hFFFF_FFFC;
    tick(); chk_pc("top", 32'hFFFF_FFFC, 1'b0, 32'd15);
    clr_in();
    check_eq("link_wrap", 64'(LinkAddr), 64'd0);
    tick();
    tick(); chk_pc("wrap", 32'h0, 1'b1, 32'd16);

    // Reset during flush bubble
    BranchControl = 1'b1; PCBranchType = 3'b000; EQ = 1'b1; BranchOffset = 32'h40;
    tick(); chk_pc("br40", 32'h40, 1'b0, 32'd17);
    clr_in();
    #2;
    reset = 1'b0;
    #1;
    chk_pc("rst_fl", 32'h0, 1'b0, 32'd0);
    check_eq("rst_fl.tval", 64'(TrapValue), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_pc("boot2", 32'h0, 1'b0, 32'd0);
    tick(); chk_pc("run0b", 32'h0, 1'b1, 32'd0);
    tick(); chk_pc("run4b", 32'h4, 1'b1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
